// File: rtl/mod_instruction_mem_ram.sv
// Loadable instruction memory: loader port writes a DEPTH-word array and tracks
// program length; fetch port gives registered one-cycle-latency reads with valid/ready.
module mod_instruction_mem_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 30,
  parameter int DEPTH      = 64,
  parameter int LEN_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_clear,
  output logic                  load_err,
  output logic [LEN_WIDTH-1:0]  prog_len,
  input  logic                  fetch_valid,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  mem_end
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                 load_in_range;
  logic                 fetch_accept;
  logic                 fetch_end;
  logic [IDX_W-1:0]     load_idx;
  logic [IDX_W-1:0]     fetch_idx;
  logic [LEN_WIDTH-1:0] load_len;
  logic [LEN_WIDTH-1:0] base_len;
  logic [LEN_WIDTH-1:0] next_len;

  assign load_in_range = ({1'b0, load_addr} < DEPTH_EXT);
  assign load_idx      = load_addr[IDX_W-1:0];
  assign load_len      = LEN_WIDTH'(load_addr) + LEN_WIDTH'(1);
  assign base_len      = load_clear ? '0 : prog_len;

  always_comb begin
    next_len = base_len;
    if (load_en && load_in_range && (load_len > base_len)) begin
      next_len = load_len;
    end
  end

  // Handshake: a request transfers on an edge where fetch_valid && fetch_ready;
  // a response transfers on an edge where resp_valid && resp_ready. The single
  // output register frees up in the same cycle its content is consumed, and
  // fetch_ready never depends on fetch_valid.
  assign fetch_ready  = !resp_valid || resp_ready;
  assign fetch_accept = fetch_valid && fetch_ready;

  // Anything at or past prog_len (including past DEPTH) never touches the array.
  assign fetch_end = ({1'b0, fetch_addr} >= (ADDR_WIDTH + 1)'(prog_len));
  assign fetch_idx = fetch_addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst && load_en && load_in_range) begin
      mem[load_idx] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prog_len <= '0;
      load_err <= 1'b0;
    end else begin
      prog_len <= next_len;
      load_err <= load_en && !load_in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid  <= 1'b0;
      instruction <= '0;
      mem_end     <= 1'b0;
    end else if (fetch_accept) begin
      resp_valid  <= 1'b1;
      mem_end     <= fetch_end;
      instruction <= fetch_end ? '0 : mem[fetch_idx];
    end else if (resp_ready) begin
      resp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_instruction_mem_ram.sv
// Bench for mod_instruction_mem_ram: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the memory and handshake.
module tb_mod_instruction_mem_ram;

  localparam int DW    = 32;
  localparam int AW    = 30;
  localparam int DEPTH = 64;
  localparam int LW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          load_clear;
  logic          load_err;
  logic [LW-1:0] prog_len;
  logic          fetch_valid;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ready;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] instruction;
  logic          mem_end;

  always #5 clk = ~clk;

  mod_instruction_mem_ram #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .load_clear(load_clear), .load_err(load_err), .prog_len(prog_len),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .instruction(instruction), .mem_end(mem_end)
  );

  int n_vec  = 0;
  int n_fail = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem [DEPTH];
  int            m_len;
  bit            m_rv;
  logic [DW-1:0] m_instr;
  bit            m_end;
  bit            m_err;
  bit            m_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_len = 0; m_rv = 0; m_instr = '0; m_end = 0; m_err = 0;
      m_live = 1'b1;
    end else if (m_live) begin
      int base;
      // Responses see length and contents as they were before this edge.
      if (fetch_valid && (!m_rv || resp_ready)) begin
        m_rv    = 1;
        m_end   = (int'(fetch_addr) >= m_len) || (fetch_addr >= AW'(DEPTH));
        m_instr = m_end ? '0 : m_mem[int'(fetch_addr)];
      end else if (resp_ready) begin
        m_rv = 0;
      end
      base = load_clear ? 0 : m_len;
      if (load_en && load_addr < AW'(DEPTH)) begin
        m_mem[int'(load_addr)] = load_data;
        m_len = (int'(load_addr) + 1 > base) ? int'(load_addr) + 1 : base;
      end else begin
        m_len = base;
      end
      m_err = load_en && (load_addr >= AW'(DEPTH));
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_live) begin
      check("resp_valid",  32'(resp_valid),  32'(m_rv));
      check("instruction", instruction,      m_instr);
      check("mem_end",     32'(mem_end),     32'(m_end));
      check("prog_len",    32'(prog_len),    32'(m_len));
      check("load_err",    32'(load_err),    32'(m_err));
      check("fetch_ready", 32'(fetch_ready), 32'(!m_rv || resp_ready));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load_en = 0; load_clear = 0; fetch_valid = 0; resp_ready = 1; rst = 0;
  endtask

  task automatic load(input int addr, input logic [DW-1:0] data);
    load_en = 1; load_addr = AW'(addr); load_data = data;
    step();
    load_en = 0;
  endtask

  logic [DW-1:0] prog [4];

  initial begin
    prog[0] = 32'h00210822; prog[1] = 32'h20230001;
    prog[2] = 32'h0C010005; prog[3] = 32'h0061102A;
    load_addr = '0; load_data = '0; fetch_addr = '0;
    idle();
    rst = 1;
    repeat (3) step();
    rst = 0;
    check("rst_prog_len",    32'(prog_len),   32'd0);
    check("rst_resp_valid",  32'(resp_valid), 32'd0);
    check("rst_instruction", instruction,     32'd0);

    // Fill every word so no fetch can ever see uninitialised storage.
    for (int i = 0; i < DEPTH; i++) load(i, $urandom);
    load_clear = 1; step(); load_clear = 0;
    check("clear_prog_len", 32'(prog_len), 32'd0);

    for (int i = 0; i < 4; i++) load(i, prog[i]);
    check("load4_prog_len", 32'(prog_len), 32'd4);

    // Back-to-back fetch of the program.
    resp_ready = 1; fetch_valid = 1;
    for (int i = 0; i < 4; i++) begin
      fetch_addr = AW'(i);
      step();
      check("b2b_valid", 32'(resp_valid), 32'd1);
      check("b2b_instr", instruction, prog[i]);
      check("b2b_end",   32'(mem_end), 32'd0);
    end

    // Past program end and past DEPTH.
    fetch_addr = AW'(4); step();
    check("end4_instr", instruction, 32'd0);
    check("end4_flag",  32'(mem_end), 32'd1);
    fetch_addr = AW'(1000); step();
    check("end1000_instr", instruction, 32'd0);
    check("end1000_flag",  32'(mem_end), 32'd1);

    // Stall with a competing request.
    fetch_addr = AW'(2); step();
    resp_ready = 0; fetch_addr = AW'(3);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ready", 32'(fetch_ready), 32'd0);
      step();
      check("stall_instr", instruction, 32'h0C010005);
      check("stall_valid", 32'(resp_valid), 32'd1);
    end
    resp_ready = 1; #1;
    check("release_ready", 32'(fetch_ready), 32'd1);
    step();
    check("release_instr", instruction, prog[3]);

    // Same-cycle load and fetch of one address reads the old word.
    fetch_addr = AW'(1); load_en = 1; load_addr = AW'(1); load_data = 32'hDEADBEEF;
    step();
    load_en = 0;
    check("rdold_instr", instruction, 32'h20230001);
    step();
    check("rdnew_instr", instruction, 32'hDEADBEEF);
    fetch_valid = 0; step();

    // Out-of-range load, then clear with a load in one cycle.
    load(64, 32'h12345678);
    check("err_pulse",   32'(load_err), 32'd1);
    check("err_prog_len", 32'(prog_len), 32'd4);
    step();
    check("err_cleared", 32'(load_err), 32'd0);
    load_clear = 1; load_en = 1; load_addr = AW'(2); load_data = 32'h0C010005;
    step();
    load_clear = 0; load_en = 0;
    check("clrload_prog_len", 32'(prog_len), 32'd3);

    // Reset while a response is stalled.
    fetch_valid = 1; fetch_addr = AW'(0); step();
    fetch_valid = 0; resp_ready = 0; step();
    rst = 1; step(); rst = 0;
    check("rst2_valid", 32'(resp_valid), 32'd0);
    check("rst2_instr", instruction, 32'd0);
    check("rst2_end",   32'(mem_end), 32'd0);
    check("rst2_len",   32'(prog_len), 32'd0);
    resp_ready = 1; fetch_valid = 1; fetch_addr = AW'(0); step();
    check("rst2_fetch_end", 32'(mem_end), 32'd1);
    fetch_valid = 0;

    // Randomized concurrent traffic.
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 199) == 0);
      load_clear = ($urandom_range(0, 39) == 0);
      load_en    = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 9))
        0:       load_addr = AW'($urandom);
        1:       load_addr = AW'($urandom_range(64, 70));
        default: load_addr = AW'($urandom_range(0, DEPTH - 1));
      endcase
      load_data   = $urandom;
      fetch_valid = ($urandom_range(0, 9) < 7);
      fetch_addr  = ($urandom_range(0, 15) == 0) ? AW'($urandom)
                                                 : AW'($urandom_range(0, 70));
      resp_ready  = ($urandom_range(0, 9) < 7);
      step();
    end
    idle();
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_instruction_mem_ram.md
Name: mod_instruction_mem_ram

Overview:
Parametrised, loadable instruction memory for the MIPS datapath, and the successor to the fixed combinational instruction ROM. A loader port writes words into a DEPTH-entry array and tracks the program length. The fetch side uses a registered, one-cycle-latency read with a valid/ready handshake and a one-entry output register. Addresses at or beyond the loaded program length return 0 and flag mem_end.

Parameters:
DATA_WIDTH, 32, instruction word width
ADDR_WIDTH, 30, word-address width (byte address >> 2)
DEPTH, 64, number of instruction words stored (power of two not required, 1..2^ADDR_WIDTH)
LEN_WIDTH, $clog2(DEPTH)+1, width of program-length counter (derived)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
load_en  input  1  write load_data to load_addr this cycle
load_addr  input  ADDR_WIDTH  word address for load
load_data  input  DATA_WIDTH  instruction word to store
load_clear  input  1  reset program length to 0 (array contents untouched)
load_err  output  1  one-cycle pulse: previous load_addr >= DEPTH, write dropped
prog_len  output  LEN_WIDTH  number of valid words (highest loaded address + 1)
fetch_valid  input  1  fetch request present
fetch_addr  input  ADDR_WIDTH  word address to fetch
fetch_ready  output  1  request accepted when fetch_valid && fetch_ready
resp_valid  output  1  instruction/mem_end valid
resp_ready  input  1  consumer takes response when resp_valid && resp_ready
instruction  output  DATA_WIDTH  fetched word
mem_end  output  1  fetched address >= prog_len at acceptance time

Behaviour:
- Reset (rst=1 at an edge): prog_len=0, resp_valid=0, instruction=0, mem_end=0, load_err=0. Array contents are not reset. rst overrides all other inputs that cycle, and a pending response is discarded.
- fetch_ready = !resp_valid || resp_ready. It is combinational and involves no fetch_valid→fetch_ready path.
- Load, per edge:
  - If load_clear: prog_len <= 0.
  - If load_en and load_addr < DEPTH: mem[load_addr] <= load_data and prog_len <= max(base, load_addr+1). base is 0 when load_clear is set in the same cycle, otherwise the current prog_len.
  - If load_en and load_addr >= DEPTH: no write; load_err <= 1 for exactly one cycle. Otherwise load_err <= 0.
- Fetch accept (fetch_valid && fetch_ready) at edge N:
  - At N+1: resp_valid=1.
  - mem_end = (fetch_addr >= prog_len), using prog_len before edge N.
  - instruction = mem_end ? 0 : mem[fetch_addr], using array contents before edge N. This is read-old on a same-cycle load to the same address.
- Stall: resp_valid && !resp_ready holds instruction, mem_end and resp_valid stable. fetch_ready=0, so no new accept.
- Consume without new accept (resp_ready=1, fetch_valid=0): resp_valid <= 0. instruction and mem_end keep their last values.
- Back-to-back: with fetch_valid and resp_ready held high, one response per cycle, full throughput.
- An address >= DEPTH is always >= prog_len, so it returns 0 with mem_end=1 and no array access.
- Loads proceed concurrently with fetches. No ordering beyond the read-old rule above.
- load_clear mid-program: fetches accepted after the clearing edge see prog_len=0 and return mem_end=1.

Test Plan:
- Reset, then load addr 0..3 = 0x00210822, 0x20230001, 0x0C010005, 0x0061102A → prog_len=4. Fetch 0..3 with resp_ready=1 → those words on 4 consecutive cycles, mem_end=0, one-cycle latency.
- Fetch addr 4 and addr 1000 (DEPTH=64) → instruction=0, mem_end=1 for both.
- Stall: accept addr 2, hold resp_ready=0 for 3 cycles → instruction stays 0x0C010005, fetch_ready=0, a new fetch_valid is ignored. Release → the next request is accepted the same cycle.
- Same-cycle load addr 1=0xDEADBEEF with a fetch of addr 1 → the response is 0x20230001. A re-fetch the following cycle → 0xDEADBEEF.
- load_addr=64 with DEPTH=64 → load_err pulses exactly 1 cycle, prog_len unchanged. load_clear+load_en addr 2 in the same cycle → prog_len=3.
- Assert rst while resp_valid=1 and stalled → next cycle resp_valid=0, instruction=0, mem_end=0, prog_len=0. A fetch of addr 0 then gives mem_end=1.
